// File: rtl/blend_layer_sorter_pkg.sv
// gfx_layer_pkg: shared types for the blend layer sorter.
//   layer_desc_t  : 20-bit layer descriptor handed to the special colour processor
//   layer_cand_t  : one ranked candidate {descriptor, BGR555 colour, rank}
//   sort_state_t  : sorter FSM states
//   backdrop_cand : builds the backdrop candidate (rank below every real layer)
package gfx_layer_pkg;
  localparam int DESC_W    = 20;
  localparam int DESC_OBJ  = 17;
  localparam int DESC_BD   = 16;
  localparam int DESC_SEMI = 13;
  localparam int DESC_BG   = 8;   // lsb of the 2-bit BG index field
  localparam int RANK_W    = 3;
  localparam int COLOR_W   = 15;

  localparam logic [RANK_W-1:0] BACKDROP_RANK = 3'd4;

  typedef logic [DESC_W-1:0] layer_desc_t;

  typedef struct packed {
    layer_desc_t              desc;
    logic [COLOR_W-1:0]       color;
    logic [RANK_W-1:0]        rank;
  } layer_cand_t;

  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_DONE} sort_state_t;

  function automatic layer_cand_t backdrop_cand(input logic [COLOR_W-1:0] c);
    layer_cand_t r;
    r              = '0;
    r.desc[DESC_BD] = 1'b1;
    r.color        = c;
    r.rank         = BACKDROP_RANK;
    return r;
  endfunction
endpackage

// File: rtl/blend_layer_sorter_if.sv
// Pixel bundle in / sorted layer pair out, both valid/ready.
//   master : line-fetch / blend side (drives bundle and out_ready)
//   slave  : the sorter
interface blend_layer_sorter_if #(
  parameter int NUM_BG = 4,
  parameter int PRIO_W = 2
);
  logic                     in_valid;
  logic                     in_ready;
  logic [16*NUM_BG-1:0]     bg_color;
  logic [NUM_BG-1:0]        bg_opaque;
  logic [NUM_BG-1:0]        bg_enable;
  logic [PRIO_W*NUM_BG-1:0] bg_prio;
  logic [15:0]              obj_color;
  logic                     obj_opaque;
  logic                     obj_enable;
  logic [PRIO_W-1:0]        obj_prio;
  logic                     obj_semitrans;
  logic [15:0]              backdrop_color;
  logic                     out_valid;
  logic                     out_ready;
  logic [19:0]              layer0;
  logic [19:0]              layer1;
  logic [15:0]              color0;
  logic [15:0]              color1;

  modport master (
    output in_valid, bg_color, bg_opaque, bg_enable, bg_prio,
           obj_color, obj_opaque, obj_enable, obj_prio, obj_semitrans,
           backdrop_color, out_ready,
    input  in_ready, out_valid, layer0, layer1, color0, color1
  );

  modport slave (
    input  in_valid, bg_color, bg_opaque, bg_enable, bg_prio,
           obj_color, obj_opaque, obj_enable, obj_prio, obj_semitrans,
           backdrop_color, out_ready,
    output in_ready, out_valid, layer0, layer1, color0, color1
  );
endinterface

// File: rtl/blend_layer_sorter_rank_insert.sv
// layer_rank_insert: combinational insert of one candidate into the running
// {best, second} pair. Strict '<' so an earlier-scanned candidate keeps its
// place on a rank tie.
//   live           : candidate is enabled and opaque
//   cand           : candidate being scanned
//   best/second    : current top two
//   best_n/second_n: updated top two
module layer_rank_insert
  import gfx_layer_pkg::*;
(
  input  logic        live,
  input  layer_cand_t cand,
  input  layer_cand_t best,
  input  layer_cand_t second,
  output layer_cand_t best_n,
  output layer_cand_t second_n
);
  always_comb begin
    best_n   = best;
    second_n = second;
    if (live && (cand.rank < best.rank)) begin
      best_n   = cand;
      second_n = best;
    end else if (live && (cand.rank < second.rank)) begin
      second_n = cand;
    end
  end
endmodule

// File: rtl/blend_layer_sorter.sv
// blend_layer_sorter: ranks OBJ, BG0..BG(NUM_BG-1) and the backdrop for one
// pixel and returns the two frontmost layers (1st/2nd blend targets).
//   clock, reset : rising-edge clock, synchronous active-high reset
//   bus (slave)  : bundle in (in_valid/in_ready), result out (out_valid/out_ready,
//                  layer0/layer1 descriptors, color0/color1 BGR555)
// One pixel in flight: accept in IDLE, one candidate per SCAN cycle (OBJ
// first, then BGs in index order), result held in DONE until out_ready.
module blend_layer_sorter
  import gfx_layer_pkg::*;
#(
  parameter int NUM_BG = 4,
  parameter int PRIO_W = 2
) (
  input  logic                 clock,
  input  logic                 reset,
  blend_layer_sorter_if.slave  bus
);
  localparam int IDX_W = $clog2(NUM_BG + 1);

  sort_state_t state, state_n;
  logic [IDX_W-1:0] idx;
  logic accept, last;

  // Bundle captured at accept; enable & opaque folded into one live bit.
  logic [NUM_BG-1:0][COLOR_W-1:0] bg_color_q;
  logic [NUM_BG-1:0][PRIO_W-1:0]  bg_prio_q;
  logic [NUM_BG-1:0]              bg_live_q;
  logic [COLOR_W-1:0]             obj_color_q;
  logic [PRIO_W-1:0]              obj_prio_q;
  logic                           obj_live_q;
  logic                           obj_semi_q;

  layer_cand_t best, second, best_n, second_n, cand;
  logic        cand_live;

  layer_desc_t        layer0_q, layer1_q;
  logic [COLOR_W-1:0] color0_q, color1_q;

  assign accept = (state == S_IDLE) && bus.in_valid;
  assign last   = (idx == IDX_W'(NUM_BG));

  always_ff @(posedge clock) begin
    if (reset) state <= S_IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      S_IDLE: if (bus.in_valid)  state_n = S_SCAN;
      S_SCAN: if (last)          state_n = S_DONE;
      S_DONE: if (bus.out_ready) state_n = S_IDLE;
      default:                   state_n = S_IDLE;
    endcase
  end

  // Candidate for the current scan slot: idx 0 = OBJ, idx k = BG(k-1).
  always_comb begin
    cand      = '0;
    cand_live = 1'b0;
    if (idx == '0) begin
      cand_live                = obj_live_q;
      cand.desc[DESC_OBJ]      = 1'b1;
      cand.desc[DESC_SEMI]     = obj_semi_q;
      cand.desc[PRIO_W-1:0]    = obj_prio_q;
      cand.color               = obj_color_q;
      cand.rank                = RANK_W'(obj_prio_q);
    end
    for (int i = 0; i < NUM_BG; i++) begin
      if (idx == IDX_W'(i + 1)) begin
        cand_live               = bg_live_q[i];
        cand.desc[DESC_BG +: 2] = 2'(i);
        cand.desc[PRIO_W-1:0]   = bg_prio_q[i];
        cand.color              = bg_color_q[i];
        cand.rank               = RANK_W'(bg_prio_q[i]);
      end
    end
  end

  layer_rank_insert u_insert (
    .live     (cand_live),
    .cand     (cand),
    .best     (best),
    .second   (second),
    .best_n   (best_n),
    .second_n (second_n)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      idx      <= '0;
      layer0_q <= '0;
      layer1_q <= '0;
      color0_q <= '0;
      color1_q <= '0;
    end else begin
      if (accept) begin
        for (int i = 0; i < NUM_BG; i++) begin
          bg_color_q[i] <= bus.bg_color[16*i +: COLOR_W];
          bg_prio_q[i]  <= bus.bg_prio[PRIO_W*i +: PRIO_W];
          bg_live_q[i]  <= bus.bg_enable[i] & bus.bg_opaque[i];
        end
        obj_color_q <= bus.obj_color[COLOR_W-1:0];
        obj_prio_q  <= bus.obj_prio;
        obj_live_q  <= bus.obj_enable & bus.obj_opaque;
        obj_semi_q  <= bus.obj_semitrans;
        best        <= backdrop_cand(bus.backdrop_color[COLOR_W-1:0]);
        second      <= backdrop_cand(bus.backdrop_color[COLOR_W-1:0]);
        idx         <= '0;
      end
      if (state == S_SCAN) begin
        best   <= best_n;
        second <= second_n;
        idx    <= idx + 1'b1;
        // Result registers load straight from the final insert so DONE
        // starts the cycle after the last candidate.
        if (last) begin
          layer0_q <= best_n.desc;
          layer1_q <= second_n.desc;
          color0_q <= best_n.color;
          color1_q <= second_n.color;
        end
      end
    end
  end

  assign bus.in_ready  = (state == S_IDLE);
  assign bus.out_valid = (state == S_DONE);
  assign bus.layer0    = layer0_q;
  assign bus.layer1    = layer1_q;
  assign bus.color0    = {1'b0, color0_q};
  assign bus.color1    = {1'b0, color1_q};

  // Input colour bit 15 carries no meaning here; output bit 15 is always 0.
  logic unused_msb;
  always_comb begin
    unused_msb = bus.obj_color[15] ^ bus.backdrop_color[15];
    for (int i = 0; i < NUM_BG; i++) unused_msb = unused_msb ^ bus.bg_color[16*i+15];
  end
endmodule
